// File: rtl/zigbee_fifo_apb_arbiter_if.sv
// Bundle of requester handshakes and the shared APB FIFO port for zigbee_fifo_apb_arbiter.
// The master modport is the arbiter side; slave is the requester/FIFO environment side.
interface zigbee_fifo_apb_arbiter_if;
    logic       tx_req_i;
    logic [7:0] tx_data_i;
    logic       tx_ack_o;
    logic       tx_err_o;
    logic       rx_req_i;
    logic       rx_ack_o;
    logic       rx_err_o;
    logic [7:0] rx_data_o;
    logic       psel_tx_o;
    logic       psel_rx_o;
    logic       penable_o;
    logic       pwrite_o;
    logic [7:0] pwdata_o;
    logic [7:0] prdata_i;
    logic       pready_tx_i;
    logic       pready_rx_i;
    logic       pslverr_tx_i;
    logic       pslverr_rx_i;
    logic       busy_o;
    logic       timeout_o;

    modport master (
        input  tx_req_i, tx_data_i, rx_req_i, prdata_i,
               pready_tx_i, pready_rx_i, pslverr_tx_i, pslverr_rx_i,
        output tx_ack_o, tx_err_o, rx_ack_o, rx_err_o, rx_data_o,
               psel_tx_o, psel_rx_o, penable_o, pwrite_o, pwdata_o,
               busy_o, timeout_o
    );

    modport slave (
        output tx_req_i, tx_data_i, rx_req_i, prdata_i,
               pready_tx_i, pready_rx_i, pslverr_tx_i, pslverr_rx_i,
        input  tx_ack_o, tx_err_o, rx_ack_o, rx_err_o, rx_data_o,
               psel_tx_o, psel_rx_o, penable_o, pwrite_o, pwdata_o,
               busy_o, timeout_o
    );
endinterface

// File: rtl/zigbee_fifo_apb_arbiter.sv
// Round-robin arbiter that turns Tx-write / Rx-read requests into two-phase APB
// transfers on the shared FIFO port, with a bounded pready wait and error return.
module zigbee_fifo_apb_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    zigbee_fifo_apb_arbiter_if.master   bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        G_TX = 1'b0,
        G_RX = 1'b1
    } grant_e;

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d, last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d, tout_q, tout_d;
    logic [7:0]      pwdata_q, pwdata_d, rx_data_q, rx_data_d;
    logic            psel_tx_q, psel_tx_d, psel_rx_q, psel_rx_d;
    logic            penable_q, penable_d, pwrite_q, pwrite_d;
    logic            tx_ack_q, tx_ack_d, tx_err_q, tx_err_d;
    logic            rx_ack_q, rx_ack_d, rx_err_q, rx_err_d;
    logic            timeout_q, timeout_d, busy_q, busy_d;
    logic            sel_ready, sel_err, xfer_phase;

    // Only the granted slave's handshake is ever looked at.
    assign sel_ready = (grant_q == G_RX) ? bus.pready_rx_i  : bus.pready_tx_i;
    assign sel_err   = (grant_q == G_RX) ? bus.pslverr_rx_i : bus.pslverr_tx_i;
    assign cnt_inc   = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        tout_d       = tout_q;
        pwdata_d     = pwdata_q;
        rx_data_d    = rx_data_q;

        case (state_q)
            S_IDLE: begin
                cnt_d  = {CW{1'b0}};
                err_d  = 1'b0;
                tout_d = 1'b0;
                if (bus.tx_req_i && bus.rx_req_i) begin
                    grant_d = (last_grant_q == G_RX) ? G_TX : G_RX;
                    state_d = S_SETUP;
                end else if (bus.tx_req_i) begin
                    grant_d = G_TX;
                    state_d = S_SETUP;
                end else if (bus.rx_req_i) begin
                    grant_d = G_RX;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
                if (state_d == S_SETUP) begin
                    last_grant_d = grant_d;
                    if (grant_d == G_TX) begin
                        pwdata_d = bus.tx_data_i;
                    end else begin
                        pwdata_d = pwdata_q;
                    end
                end else begin
                    last_grant_d = last_grant_q;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (sel_ready) begin
                    err_d   = sel_err;
                    state_d = S_DONE;
                    if (grant_q == G_RX) begin
                        rx_data_d = bus.prdata_i;
                    end else begin
                        rx_data_d = rx_data_q;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMAX) begin
                        err_d   = 1'b1;
                        tout_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        xfer_phase = (state_d == S_SETUP) || (state_d == S_ACCESS);
        busy_d     = (state_d != S_IDLE);
        psel_tx_d  = xfer_phase && (grant_d == G_TX);
        psel_rx_d  = xfer_phase && (grant_d == G_RX);
        penable_d  = (state_d == S_ACCESS);
        pwrite_d   = xfer_phase && (grant_d == G_TX);
        tx_ack_d   = (state_d == S_DONE) && (grant_d == G_TX);
        rx_ack_d   = (state_d == S_DONE) && (grant_d == G_RX);
        tx_err_d   = tx_ack_d && err_d;
        rx_err_d   = rx_ack_d && err_d;
        timeout_d  = (state_d == S_DONE) && tout_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= G_TX;
            last_grant_q <= G_RX;
            cnt_q        <= {CW{1'b0}};
            err_q        <= 1'b0;
            tout_q       <= 1'b0;
            pwdata_q     <= 8'h00;
            rx_data_q    <= 8'h00;
            psel_tx_q    <= 1'b0;
            psel_rx_q    <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            tx_ack_q     <= 1'b0;
            tx_err_q     <= 1'b0;
            rx_ack_q     <= 1'b0;
            rx_err_q     <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            tout_q       <= tout_d;
            pwdata_q     <= pwdata_d;
            rx_data_q    <= rx_data_d;
            psel_tx_q    <= psel_tx_d;
            psel_rx_q    <= psel_rx_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            tx_ack_q     <= tx_ack_d;
            tx_err_q     <= tx_err_d;
            rx_ack_q     <= rx_ack_d;
            rx_err_q     <= rx_err_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.psel_tx_o = psel_tx_q;
    assign bus.psel_rx_o = psel_rx_q;
    assign bus.penable_o = penable_q;
    assign bus.pwrite_o  = pwrite_q;
    assign bus.pwdata_o  = pwdata_q;
    assign bus.rx_data_o = rx_data_q;
    assign bus.tx_ack_o  = tx_ack_q;
    assign bus.tx_err_o  = tx_err_q;
    assign bus.rx_ack_o  = rx_ack_q;
    assign bus.rx_err_o  = rx_err_q;
    assign bus.timeout_o = timeout_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_zigbee_fifo_apb_arbiter.sv
// Self-checking bench for zigbee_fifo_apb_arbiter: directed scenarios followed by
// randomized transactions checked cycle by cycle against a transaction-level model.
module tb_zigbee_fifo_apb_arbiter;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zigbee_fifo_apb_arbiter_if bus();

    zigbee_fifo_apb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who was served last, register contents, held requests.
    bit         m_last_rx;
    logic [7:0] m_pwdata;
    logic [7:0] m_rxdata;
    bit         pend_tx;
    bit         pend_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {busy, psel_tx, psel_rx, penable, pwrite, tx_ack, tx_err, rx_ack, rx_err, timeout}
    function automatic logic [9:0] obs();
        return {bus.busy_o, bus.psel_tx_o, bus.psel_rx_o, bus.penable_o, bus.pwrite_o,
                bus.tx_ack_o, bus.tx_err_o, bus.rx_ack_o, bus.rx_err_o, bus.timeout_o};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last_rx = 1'b1;
        m_pwdata  = 8'h00;
        m_rxdata  = 8'h00;
        pend_tx   = 1'b0;
        pend_rx   = 1'b0;
    endtask

    // One arbitration round starting in IDLE: w = ACCESS cycles with pready low before it rises.
    task automatic do_txn(input bit ntx, input bit nrx, input logic [7:0] d, input int w,
                          input bit perr, input logic [7:0] prd, input string tag);
        bit          g_rx;
        bit          to;
        bit          err;
        int          a;
        logic [9:0]  e;
        if (ntx && !pend_tx) begin
            pend_tx       = 1'b1;
            bus.tx_data_i = d;
        end
        if (nrx) pend_rx = 1'b1;
        bus.tx_req_i = pend_tx;
        bus.rx_req_i = pend_rx;
        bus.prdata_i = prd;
        if (!pend_tx && !pend_rx) begin
            @(negedge clk);
            check({tag, " idle"}, {22'd0, obs()}, 32'd0);
            next_cycle();
            return;
        end
        g_rx      = (pend_tx && pend_rx) ? !m_last_rx : pend_rx;
        m_last_rx = g_rx;
        if (!g_rx) m_pwdata = bus.tx_data_i;
        to  = (w >= T);
        err = to || perr;
        a   = to ? 2 + T : 3 + w;
        if (g_rx && !to) m_rxdata = prd;
        // The idle slave shows ready+error to catch sampling of the wrong handshake.
        bus.pready_tx_i  = g_rx;
        bus.pslverr_tx_i = g_rx ? 1'b1 : perr;
        bus.pready_rx_i  = !g_rx;
        bus.pslverr_rx_i = g_rx ? perr : 1'b1;
        for (int k = 0; k <= a; k++) begin
            if (g_rx) bus.pready_rx_i = (k == 2 + w);
            else      bus.pready_tx_i = (k == 2 + w);
            @(negedge clk);
            if (k == 0) begin
                e = 10'd0;
            end else if (k < a) begin
                e = {1'b1, !g_rx, g_rx, (k >= 2), !g_rx, 5'b00000};
            end else begin
                e = {5'b10000, !g_rx, !g_rx && err, g_rx, g_rx && err, to};
            end
            check($sformatf("%s c%0d ctl", tag, k), {22'd0, obs()}, {22'd0, e});
            if (k == a) begin
                check({tag, " pwdata"}, {24'd0, bus.pwdata_o}, {24'd0, m_pwdata});
                check({tag, " rxdata"}, {24'd0, bus.rx_data_o}, {24'd0, m_rxdata});
            end
            next_cycle();
        end
        if (g_rx) pend_rx = 1'b0;
        else      pend_tx = 1'b0;
        bus.tx_req_i = pend_tx;
        bus.rx_req_i = pend_rx;
    endtask

    initial begin
        bus.tx_req_i     = 1'b0;
        bus.rx_req_i     = 1'b0;
        bus.tx_data_i    = 8'h00;
        bus.prdata_i     = 8'h00;
        bus.pready_tx_i  = 1'b0;
        bus.pready_rx_i  = 1'b0;
        bus.pslverr_tx_i = 1'b0;
        bus.pslverr_rx_i = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset ctl", {22'd0, obs()}, 32'd0);
        check("reset data", {16'd0, bus.pwdata_o, bus.rx_data_o}, 32'd0);
        rst = 1'b0;
        next_cycle();

        do_txn(1'b1, 1'b0, 8'hA5, 0,  1'b0, 8'h00, "single_tx");
        do_txn(1'b0, 1'b1, 8'h00, 3,  1'b0, 8'h3C, "rx_wait");
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, 8'h40 + 8'(i), 0, 1'b0, 8'h80 + 8'(i), $sformatf("tie%0d", i));
        end
        do_txn(1'b1, 1'b0, 8'h77, 40, 1'b0, 8'h00, "timeout");
        do_txn(1'b0, 1'b1, 8'h00, 0,  1'b1, 8'h11, "slverr");
        do_txn(1'b0, 1'b1, 8'h00, T - 1, 1'b0, 8'h5E, "last_wait");

        // Reset while stuck in ACCESS, then a tie must go to Tx first.
        bus.tx_req_i     = 1'b1;
        bus.tx_data_i    = 8'h5A;
        bus.pready_tx_i  = 1'b0;
        bus.pready_rx_i  = 1'b0;
        for (int k = 0; k < 3; k++) next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_mid ctl", {22'd0, obs()}, 32'd0);
        check("rst_mid data", {16'd0, bus.pwdata_o, bus.rx_data_o}, 32'd0);
        rst = 1'b0;
        bus.tx_req_i = 1'b0;
        model_reset();
        next_cycle();
        do_txn(1'b1, 1'b1, 8'hC3, 1, 1'b0, 8'h99, "post_rst_tie");
        do_txn(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h99, "post_rst_rx");

        for (int i = 0; i < 150; i++) begin
            int w;
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(0, 4);
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   w, 1'($urandom_range(0, 3) == 0), 8'($urandom), $sformatf("rnd%0d", i));
        end
        // Drain any request still pending.
        for (int i = 0; i < 2; i++) do_txn(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
